// File: rtl/camera_pkg.sv
// Shared types and RGB565 colour-bar constants for the camera capture front end.
package camera_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} cap_state_t;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/shutter_debounce.sv
// Shutter switch: 2-flop synchroniser, stability counter, debounced level and
// a one-cycle press pulse coincident with the debounced rising edge.
module shutter_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic switch_in,
    output logic db_out,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_db;
    logic          r_press;
    logic          w_stable;

    assign w_stable = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], switch_in};
            r_press <= 1'b0;
            // any return to the current level restarts the stability window
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (w_stable) begin
                r_db    <= r_sync[1];
                r_press <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign db_out = r_db;
    assign press  = r_press;

endmodule

// File: rtl/camera_capture.sv
// Camera front end: registers camera pins, assembles pixels, tracks x/y and frame geometry.
// Optional build macro CAM_TEST_PATTERN_EN adds a test_pattern input selecting 8 colour bars.
module camera_capture
    import camera_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                cam_href,
    input  logic                                cam_vsync,
    input  logic [DATA_W-1:0]                   cam_data,
    input  logic                                switch_shutter,
    input  logic                                continuous,
`ifdef CAM_TEST_PATTERN_EN
    input  logic                                test_pattern,
`endif
    output logic                                pix_valid,
    output logic [DATA_W*BYTES_PER_PIXEL-1:0]   pix_data,
    output logic [$clog2(H_ACTIVE)-1:0]         pix_x,
    output logic [$clog2(V_ACTIVE)-1:0]         pix_y,
    output logic                                pix_sof,
    output logic                                pix_eol,
    output logic                                frame_done,
    output logic                                frame_err,
    output logic                                busy,
    output logic                                shutter_db
);

    localparam int PIX_W = DATA_W * BYTES_PER_PIXEL;
    localparam int ACC_W = (BYTES_PER_PIXEL > 1) ? (BYTES_PER_PIXEL - 1) * DATA_W : DATA_W;
    localparam int XW    = $clog2(H_ACTIVE);
    localparam int YW    = $clog2(V_ACTIVE);
    localparam int XC    = $clog2(H_ACTIVE + 1);
    localparam int YC    = $clog2(V_ACTIVE + 1);
    localparam int BCW   = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;

    cap_state_t        r_state, w_next;
    logic              r_href, r_href_d, r_vsync, r_vsync_d;
    logic [DATA_W-1:0] r_data;
    logic [ACC_W-1:0]  r_acc;
    logic [BCW-1:0]    r_bcnt;
    logic [XC-1:0]     r_x;
    logic [YC-1:0]     r_y;
    logic              r_err;

    logic              w_press;
    logic              w_cap, w_href_fall, w_vs_fall, w_vs_rise;
    logic              w_byte, w_last, w_in_range, w_emit;
    logic              w_row_end, w_row_err, w_rows_err, w_frame_end;
    logic [YC-1:0]     w_y_next;
    logic [PIX_W-1:0]  w_word, w_pix;

    shutter_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk       (clk),
        .reset_n   (reset_n),
        .switch_in (switch_shutter),
        .db_out    (shutter_db),
        .press     (w_press)
    );

    assign w_cap       = (r_state == CAPTURE);
    assign w_href_fall = r_href_d & ~r_href;
    assign w_vs_fall   = r_vsync_d & ~r_vsync;
    assign w_vs_rise   = ~r_vsync_d & r_vsync;
    // a vsync rise ends the frame, so the byte sampled alongside it is discarded
    assign w_byte      = w_cap & r_href & ~w_vs_rise;
    assign w_last      = w_byte & (r_bcnt == BCW'(BYTES_PER_PIXEL - 1));
    assign w_in_range  = (r_x < XC'(H_ACTIVE)) & (r_y < YC'(V_ACTIVE));
    assign w_emit      = w_last & w_in_range;
    assign w_word      = PIX_W'({r_acc, r_data});

    assign w_row_end   = w_cap & (w_href_fall | (w_vs_rise & r_href));
    assign w_row_err   = w_row_end & ((r_bcnt != '0) | (r_x != XC'(H_ACTIVE)));
    assign w_y_next    = ((r_x != '0) && (r_y != YC'(V_ACTIVE))) ? r_y + 1'b1 : r_y;
    assign w_frame_end = w_cap & w_vs_rise;
    assign w_rows_err  = w_frame_end & ((w_row_end ? w_y_next : r_y) != YC'(V_ACTIVE));

`ifdef CAM_TEST_PATTERN_EN
    logic [2:0] w_bar_idx;
    assign w_bar_idx = 3'((32'(r_x) * 8) / H_ACTIVE);
    assign w_pix     = test_pattern ? PIX_W'(bar_color(w_bar_idx)) : w_word;
`else
    assign w_pix     = w_word;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_press || continuous) w_next = WAIT_VS;
            WAIT_VS: if (w_vs_fall) w_next = CAPTURE;
            CAPTURE: if (w_vs_rise) w_next = continuous ? WAIT_VS : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_href     <= 1'b0;
            r_href_d   <= 1'b0;
            r_vsync    <= 1'b0;
            r_vsync_d  <= 1'b0;
            r_data     <= '0;
            r_acc      <= '0;
            r_bcnt     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_err      <= 1'b0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_href     <= cam_href;
            r_vsync    <= cam_vsync;
            r_data     <= cam_data;
            r_href_d   <= r_href;
            r_vsync_d  <= r_vsync;
            r_state    <= w_next;
            pix_valid  <= w_emit;
            pix_sof    <= w_emit & (r_x == '0) & (r_y == '0);
            pix_eol    <= w_emit & (r_x == XC'(H_ACTIVE - 1));
            frame_done <= w_frame_end;

            if (r_state == WAIT_VS && w_vs_fall) begin
                r_x    <= '0;
                r_y    <= '0;
                r_bcnt <= '0;
                r_err  <= 1'b0;
            end else if (w_cap) begin
                if (w_byte) begin
                    r_acc  <= w_word[ACC_W-1:0];
                    r_bcnt <= w_last ? '0 : r_bcnt + 1'b1;
                    if (w_emit) begin
                        pix_data <= w_pix;
                        pix_x    <= r_x[XW-1:0];
                        pix_y    <= r_y[YW-1:0];
                    end
                    // x saturates at H_ACTIVE so overflow never wraps back into range
                    if (w_last && r_x != XC'(H_ACTIVE))
                        r_x <= r_x + 1'b1;
                end
                if (w_row_end) begin
                    r_x    <= '0;
                    r_bcnt <= '0;
                    r_y    <= w_y_next;
                end
                if (w_row_err || (w_last && !w_in_range) || w_rows_err)
                    r_err <= 1'b1;
            end
        end
    end

    assign frame_err = r_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture with a row-level expected-pixel model and per-cycle compare.
module tb_camera_capture;

    localparam int H = 4;
    localparam int V = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cam_href = 1'b0;
    logic        cam_vsync = 1'b1;
    logic [7:0]  cam_data = 8'h00;
    logic        switch_shutter = 1'b0;
    logic        continuous = 1'b0;
`ifdef CAM_TEST_PATTERN_EN
    logic        test_pattern = 1'b0;
`endif
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [1:0]  pix_x;
    logic [0:0]  pix_y;
    logic        pix_sof, pix_eol, frame_done, frame_err, busy, shutter_db;

    camera_capture #(
        .DATA_W(8), .BYTES_PER_PIXEL(2), .H_ACTIVE(H), .V_ACTIVE(V), .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cam_href(cam_href), .cam_vsync(cam_vsync),
        .cam_data(cam_data), .switch_shutter(switch_shutter), .continuous(continuous),
`ifdef CAM_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done),
        .frame_err(frame_err), .busy(busy), .shutter_db(shutter_db)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          x;
        int          y;
        bit          sof;
        bit          eol;
    } pix_t;

    pix_t        exp_q[$];
    bit          err_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          chk_en = 1'b1;
    int          n_pix = 0, n_sof = 0, n_eol = 0, n_done = 0;
    logic [15:0] first_data = 16'h0;
    bit          got_first = 1'b0;
    logic        last_ferr = 1'b0;
    bit          tp_on = 1'b0;
    int          seed = 8'h40;
    int          row_bytes[4];
    int          n_rows = 0;
    logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bval(input bit fixed, input int r, input int i);
        if (fixed) return (i % 2 != 0) ? 8'h34 : 8'h12;
        return 8'(seed + r * 16 + i);
    endfunction

    // Compare process: every emitted pixel / frame_done must match the model queues.
    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            if (pix_valid) begin
                n_pix++;
                n_sof += int'(pix_sof);
                n_eol += int'(pix_eol);
                if (!got_first) begin
                    first_data = pix_data;
                    got_first  = 1'b1;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_pix", 32'd1, 32'd0);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    check("pix_data", 32'(pix_data), 32'(e.d));
                    check("pix_x", 32'(pix_x), 32'(e.x));
                    check("pix_y", 32'(pix_y), 32'(e.y));
                    check("pix_sof", 32'(pix_sof), 32'(e.sof));
                    check("pix_eol", 32'(pix_eol), 32'(e.eol));
                end
            end
            if (frame_done) begin
                n_done++;
                last_ferr = frame_err;
                if (err_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    bit eb;
                    eb = err_q.pop_front();
                    check("frame_err", 32'(frame_err), 32'(eb));
                end
            end
        end
    end

    // Builds the expected pixel stream from row byte counts, then drives the frame.
    task automatic drive_frame(input bit cap, input bit fixed);
        bit err;
        int rows, nb, np;
        pix_t e;
        err = 1'b0;
        rows = 0;
        if (cap) begin
            for (int r = 0; r < n_rows; r++) begin
                nb = row_bytes[r];
                np = nb / 2;
                if (nb % 2 != 0 || np != H) err = 1'b1;
                for (int p = 0; p < np; p++) begin
                    if (p < H && rows < V) begin
                        e.d   = tp_on ? bars[p * 8 / H] : {bval(fixed, r, 2 * p), bval(fixed, r, 2 * p + 1)};
                        e.x   = p;
                        e.y   = rows;
                        e.sof = (p == 0 && rows == 0);
                        e.eol = (p == H - 1);
                        exp_q.push_back(e);
                    end else begin
                        err = 1'b1;
                    end
                end
                if (np > 0) rows++;
            end
            if (rows != V) err = 1'b1;
            err_q.push_back(err);
        end
        cam_vsync = 1'b1;
        repeat (3) cyc();
        cam_vsync = 1'b0;
        repeat (2) cyc();
        for (int r = 0; r < n_rows; r++) begin
            for (int i = 0; i < row_bytes[r]; i++) begin
                cam_href = 1'b1;
                cam_data = bval(fixed, r, i);
                cyc();
            end
            cam_href = 1'b0;
            cam_data = 8'h00;
            repeat (2) cyc();
        end
        cam_vsync = 1'b1;
        repeat (4) cyc();
        seed += 37;
    endtask

    task automatic press();
        switch_shutter = 1'b1;
        repeat (20) cyc();
        check("shutter_db_high", 32'(shutter_db), 32'd1);
        switch_shutter = 1'b0;
        repeat (24) cyc();
        check("busy_after_press", 32'(busy), 32'd1);
    endtask

    task automatic set_rows(input int n, input int a, input int b, input int c);
        n_rows = n;
        row_bytes[0] = a;
        row_bytes[1] = b;
        row_bytes[2] = c;
        row_bytes[3] = 0;
    endtask

    task automatic all_zero(input string name);
        check(name, 32'({pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
                         frame_done, frame_err, busy, shutter_db}), 32'd0);
    endtask

    initial begin
        int base;
        repeat (3) cyc();
        all_zero("reset_state");
        reset_n = 1'b1;
        repeat (2) cyc();

        // 1: single-shot capture of 0x1234 pixels
        press();
        set_rows(2, 8, 8, 0);
        drive_frame(1'b1, 1'b1);
        check("t1_pix_count", 32'(n_pix), 32'd8);
        check("t1_first_data", 32'(first_data), 32'h1234);
        check("t1_sof_count", 32'(n_sof), 32'd1);
        check("t1_eol_count", 32'(n_eol), 32'd2);
        check("t1_done_count", 32'(n_done), 32'd1);
        check("t1_ferr", 32'(last_ferr), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        drive_frame(1'b0, 1'b1);
        check("t1_no_second_frame", 32'(n_pix), 32'd8);

        // 2: bouncing shutter never debounces
        repeat (20) cyc();
        for (int c = 0; c < 60; c++) begin
            if (c % 3 == 0) switch_shutter = ~switch_shutter;
            cyc();
            check("t2_shutter_db", 32'(shutter_db), 32'd0);
            check("t2_busy", 32'(busy), 32'd0);
        end
        switch_shutter = 1'b0;
        repeat (24) cyc();

        // 3: short row 1, then a clean frame
        press();
        set_rows(2, 8, 6, 0);
        base = n_eol;
        drive_frame(1'b1, 1'b0);
        check("t3_eol_only_row0", 32'(n_eol - base), 32'd1);
        check("t3_ferr_short", 32'(last_ferr), 32'd1);
        press();
        set_rows(2, 8, 8, 0);
        drive_frame(1'b1, 1'b0);
        check("t3_ferr_clean", 32'(last_ferr), 32'd0);

        // 4: odd byte count in row 0, then too many pixels and rows
        press();
        set_rows(2, 7, 8, 0);
        base = n_pix;
        drive_frame(1'b1, 1'b0);
        check("t4_pix_count", 32'(n_pix - base), 32'd7);
        check("t4_ferr_partial", 32'(last_ferr), 32'd1);
        press();
        set_rows(3, 10, 8, 8);
        base = n_pix;
        drive_frame(1'b1, 1'b0);
        check("t4_overflow_pix", 32'(n_pix - base), 32'd8);
        check("t4_ferr_overflow", 32'(last_ferr), 32'd1);

        // 5: continuous mode, three back-to-back frames
        continuous = 1'b1;
        cyc();
        base = n_done;
        set_rows(2, 8, 8, 0);
        repeat (3) drive_frame(1'b1, 1'b0);
        check("t5_done_count", 32'(n_done - base), 32'd3);
        check("t5_ferr", 32'(last_ferr), 32'd0);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: reset mid-row 1, then a clean frame in continuous mode
        chk_en = 1'b0;
        cam_vsync = 1'b1;
        repeat (3) cyc();
        cam_vsync = 1'b0;
        repeat (2) cyc();
        for (int i = 0; i < 8; i++) begin
            cam_href = 1'b1;
            cam_data = 8'(i);
            cyc();
        end
        cam_href = 1'b0;
        repeat (2) cyc();
        cam_href = 1'b1;
        repeat (3) cyc();
        reset_n = 1'b0;
        #1;
        all_zero("t6_reset_outputs");
        cam_href = 1'b0;
        cam_vsync = 1'b1;
        repeat (3) cyc();
        reset_n = 1'b1;
        chk_en = 1'b1;
`ifdef CAM_TEST_PATTERN_EN
        test_pattern = 1'b1;
        tp_on = 1'b1;
`endif
        cyc();
        base = n_sof;
        n_done = 0;
        drive_frame(1'b1, 1'b0);
        check("t6_sof_count", 32'(n_sof - base), 32'd1);
        check("t6_done_count", 32'(n_done), 32'd1);
        check("t6_ferr", 32'(last_ferr), 32'd0);
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);
        check("final_err_empty", 32'(err_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
